// File: rtl/quadrilatero_mem_arbiter.sv
// Round-robin arbiter sharing one wide memory port between NUM_REQ requesters.
// Define QUADRILATERO_MEM_ARB_STATS_EN to add grant/stall statistic counters.
module quadrilatero_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned BUS_WIDTH       = 128,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ*BUS_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*32-1:0]          addr_i,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [BUS_WIDTH-1:0]           rdata_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [BUS_WIDTH/8-1:0]         mem_be_o,
    output logic [31:0]                    mem_addr_o,
    output logic [BUS_WIDTH-1:0]           mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [BUS_WIDTH-1:0]           mem_rdata_i,
    output logic                           err_o
`ifdef QUADRILATERO_MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]          stat_grant_cnt_o,
    output logic [31:0]                    stat_stall_cnt_o
`endif
);

    localparam int unsigned BEW = BUS_WIDTH / 8;
    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;

    logic [BEW-1:0]       be_arr    [NUM_REQ];
    logic [31:0]          addr_arr  [NUM_REQ];
    logic [BUS_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_idx;
    logic [IW-1:0] rr_sel;
    logic [IW-1:0] sel;
    logic [IW-1:0] sel_next;
    logic [IW:0]   cand;
    logic          lock;
    logic          lock_hold;
    logic          any_req;
    logic          found;
    logic          grant;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          err_q;

    logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign be_arr[k]    = be_i[k*BEW +: BEW];
        assign addr_arr[k]  = addr_i[k*32 +: 32];
        assign wdata_arr[k] = wdata_i[k*BUS_WIDTH +: BUS_WIDTH];
    end

    // First asserted request at or after rr_ptr, searching circularly.
    always_comb begin
        rr_sel = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                rr_sel = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    // A locked requester that drops req_i forfeits its lock this cycle.
    assign lock_hold  = lock && req_i[lock_idx];
    assign sel        = lock_hold ? lock_idx : rr_sel;
    assign sel_next   = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);

    assign any_req    = |req_i;
    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign mem_req_o  = any_req && !fifo_full;
    assign grant      = mem_req_o && mem_gnt_i;
    assign pop        = mem_rvalid_i && !fifo_empty;
    assign rdata_o    = mem_rdata_i;
    assign err_o      = err_q;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        gnt_o       = '0;
        rvalid_o    = '0;
        if (mem_req_o) begin
            mem_we_o    = we_i[sel];
            mem_be_o    = be_arr[sel];
            mem_addr_o  = addr_arr[sel];
            mem_wdata_o = wdata_arr[sel];
        end
        if (grant) begin
            gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            rvalid_o[fifo_mem[rd_ptr]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            lock <= mem_req_o && !mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) begin
                lock_idx <= sel;
            end
            if (grant) begin
                rr_ptr <= sel_next;
                wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (grant && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !grant) begin
                count <= count - CW'(1);
            end
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            fifo_mem[wr_ptr] <= sel;
        end
    end

`ifdef QUADRILATERO_MEM_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant && (sel == IW'(k))) begin
                    grant_cnt[k] <= grant_cnt[k] + 32'd1;
                end
            end
            if (any_req && !grant) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
        assign stat_grant_cnt_o[k*32 +: 32] = grant_cnt[k];
    end
    assign stat_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: doc/quadrilatero_mem_arbiter.md
Name: quadrilatero_mem_arbiter

Overview:
- Shares the matrix coprocessor's single wide memory port (mem_req/we/be/addr/wdata/gnt/rvalid/rdata, ahead of the OBI bridge) between NUM_REQ internal requesters, e.g. the load unit and the store unit.
- Arbitrates round-robin and locks the selection while a request waits for grant, per OBI rules.
- Tracks outstanding transactions in an in-order ID FIFO and steers each rvalid/rdata back to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- BUS_WIDTH, 128, data width in bits; BE width = BUS_WIDTH/8.
- MAX_OUTSTANDING, 4, ID FIFO depth, i.e. the maximum number of granted-but-unanswered transactions (power of 2, ≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester request.
- we_i  in  NUM_REQ  per-requester write enable.
- be_i  in  NUM_REQ*BUS_WIDTH/8  packed byte enables; requester k occupies slice k.
- addr_i  in  NUM_REQ*32  packed addresses.
- wdata_i  in  NUM_REQ*BUS_WIDTH  packed write data.
- gnt_o  out  NUM_REQ  per-requester grant (one-hot or zero).
- rvalid_o  out  NUM_REQ  per-requester response valid (one-hot or zero).
- rdata_o  out  BUS_WIDTH  response data, broadcast to all requesters.
- mem_req_o  out  1  downstream request.
- mem_we_o  out  1  downstream write enable.
- mem_be_o  out  BUS_WIDTH/8  downstream byte enables.
- mem_addr_o  out  32  downstream address.
- mem_wdata_o  out  BUS_WIDTH  downstream write data.
- mem_gnt_i  in  1  downstream grant.
- mem_rvalid_i  in  1  downstream response valid; responses return in issue order.
- mem_rdata_i  in  BUS_WIDTH  downstream response data.
- err_o  out  1  sticky flag: unexpected rvalid received.

Behaviour:
- Reset: rr_ptr=0, lock=0, FIFO empty, err_o=0. With no req_i asserted, all outputs are 0.
- Selection:
  - If lock=1, sel=lock_idx.
  - Otherwise sel is the first asserted req_i at or after rr_ptr, searching circularly.
  - Selection is combinational; no added latency.
- Issue:
  - mem_req_o = any(req_i) && !fifo_full.
  - mem_we/be/addr/wdata_o = slice[sel] when mem_req_o=1, otherwise 0.
- Grant:
  - gnt_o[sel] = mem_gnt_i && mem_req_o; all other grant bits are 0.
  - On grant: push sel into the ID FIFO, set rr_ptr=(sel+1) mod NUM_REQ, clear lock.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, register lock=1, lock_idx=sel.
  - Address, data and other signals stay sourced from lock_idx until grant.
  - Requesters must hold req_i and their payload stable until gnt_o (OBI). If a locked requester drops req_i anyway, that is a protocol violation: mem_req_o follows any(req_i) and lock is released.
- Response:
  - rvalid_o[fifo_head] = mem_rvalid_i && !fifo_empty.
  - rdata_o = mem_rdata_i, always passed through combinationally.
  - Pop the FIFO on mem_rvalid_i.
- Simultaneous grant and rvalid in one cycle: push and pop together; occupancy is unchanged. When full, pop-first semantics do NOT apply: the full check uses registered occupancy, so the request waits one cycle.
- FIFO full: mem_req_o=0 and no grants until a response is popped.
- mem_rvalid_i with FIFO empty: response dropped, no rvalid_o, err_o set (sticky until reset).
- Reset mid-transaction: FIFO cleared and lock dropped asynchronously. Late downstream responses then hit the empty-FIFO path and set err_o.
- Occupancy counter is $clog2(MAX_OUTSTANDING)+1 bits; read/write pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- Macro: QUADRILATERO_MEM_ARB_STATS_EN.
- Defined: adds output stat_grant_cnt_o (NUM_REQ*32 bits, per-requester grant counters) and output stat_stall_cnt_o (32 bits, counts cycles with any(req_i)=1 and no grant, including FIFO-full cycles). Both are cleared on reset and wrap at 2^32.
- Undefined: no counters and no stat ports; behaviour is otherwise identical.

Test Plan:
1. Round-robin fairness. req_i=2'b11 held; issue cycles with mem_gnt_i=1; downstream answers each request one cycle after grant → gnt_o sequence 01,10,01,10, each rvalid_o matches the grant order, and rdata 0xA..., 0xB... is routed accordingly.
2. Lock hold. req_i=11, rr_ptr=0, mem_gnt_i=0 for 3 cycles, then 1 → mem_addr_o equals addr of requester 0 for all 4 cycles; gnt_o=01 only in cycle 4; next grant goes to requester 1.
3. Outstanding limit. MAX_OUTSTANDING=4, mem_gnt_i=1, no rvalid → exactly 4 grants, then mem_req_o=0. One rvalid → mem_req_o=1 again on the next cycle.
4. Simultaneous push/pop. Occupancy 2, grant to requester 1 and rvalid in the same cycle → head pops to its owner, occupancy stays 2, and the later response goes to requester 1.
5. Spurious response. FIFO empty, mem_rvalid_i=1 → rvalid_o=00, err_o=1 persisting until rst_ni=0.
6. Mid-flight reset. Occupancy 3, rst_ni pulsed low → mem_req_o, gnt_o, rvalid_o are 0 immediately; after release, a single req_i=10 is granted with rr_ptr=0 semantics.
